// File: rtl/uart_iram_loader_pkg.sv
// Shared types and constants for the UART-to-IRAM program loader.
// Frame FSM state encoding and word geometry.
package uart_iram_loader_pkg;

    localparam int BYTES_PER_WORD = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_HI,
        ST_RD_LO,
        ST_WRITE,
        ST_CHK
    } state_t;

endpackage

// File: rtl/uart_iram_loader_fetch.sv
// UART FIFO pop handshake with a one-cycle settle guard and an
// inter-byte idle timeout counter.
module uart_byte_fetch #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_empty_i,
    input  logic [7:0] r_data_i,
    input  logic       rd_en_i,
    input  logic       tmo_en_i,
    output logic       rd_uart_o,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       timeout_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic          guard_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          accept;

    assign accept       = rd_en_i & ~rx_empty_i & ~guard_q;
    assign rd_uart_o    = accept;
    assign byte_valid_o = accept;
    assign byte_o       = r_data_i;

    // Counter clears on any accepted byte and whenever timing is disabled.
    always_comb begin
        cnt_d     = '0;
        timeout_o = 1'b0;
        if (tmo_en_i && !accept) begin
            if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                timeout_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            guard_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            guard_q <= accept;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_iram_loader.sv
// Framed UART program loader: length, MSB-first word bytes, XOR checksum.
// Holds the CPU in reset while a frame is being written into IRAM.
module uart_iram_loader
    import uart_iram_loader_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int IRAM_ADDR_BITS = 8,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx_empty,
    input  logic [7:0]                r_data,
    output logic                      rd_uart,
    output logic [IRAM_ADDR_BITS-1:0] iram_wa,
    output logic                      iram_wen,
    output logic [WIDTH-1:0]          iram_din,
    output logic                      cpu_hold,
    output logic                      done,
    output logic                      err,
    output logic [IRAM_ADDR_BITS:0]   words_loaded
);

    localparam int WLW = IRAM_ADDR_BITS + 1;

    state_t                    state_q, state_d;
    logic [7:0]                n_q, n_d;
    logic [7:0]                hi_q, hi_d;
    logic [7:0]                lo_q, lo_d;
    logic [7:0]                chk_q, chk_d;
    logic [IRAM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [WLW-1:0]            wl_q, wl_d;
    logic [WLW-1:0]            wl_inc;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic                      hold_q, hold_d;

    logic       rd_en;
    logic       tmo_en;
    logic       bv;
    logic [7:0] b;
    logic       tmo;

    assign rd_en  = (state_q != ST_WRITE);
    assign tmo_en = (state_q == ST_RD_HI) || (state_q == ST_RD_LO) ||
                    (state_q == ST_CHK);

    uart_byte_fetch #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_fetch (
        .clk         (clk),
        .reset       (reset),
        .rx_empty_i  (rx_empty),
        .r_data_i    (r_data),
        .rd_en_i     (rd_en),
        .tmo_en_i    (tmo_en),
        .rd_uart_o   (rd_uart),
        .byte_valid_o(bv),
        .byte_o      (b),
        .timeout_o   (tmo)
    );

    assign wl_inc = wl_q + 1'b1;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        chk_d   = chk_q;
        addr_d  = addr_q;
        wl_d    = wl_q;
        done_d  = done_q;
        err_d   = err_q;
        hold_d  = hold_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bv) begin
                    n_d     = b;
                    chk_d   = 8'h00;
                    addr_d  = '0;
                    wl_d    = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    hold_d  = 1'b1;
                    state_d = (b == 8'h00) ? ST_CHK : ST_RD_HI;
                end
            end
            ST_RD_HI: begin
                if (bv) begin
                    hi_d    = b;
                    chk_d   = chk_q ^ b;
                    state_d = ST_RD_LO;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    hold_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_RD_LO: begin
                if (bv) begin
                    lo_d    = b;
                    chk_d   = chk_q ^ b;
                    state_d = ST_WRITE;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    hold_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                addr_d  = addr_q + 1'b1;
                wl_d    = wl_inc;
                state_d = (wl_inc == WLW'(n_q)) ? ST_CHK : ST_RD_HI;
            end
            ST_CHK: begin
                // Length byte is deliberately outside the checksum.
                if (bv) begin
                    done_d  = (b == chk_q);
                    err_d   = (b != chk_q);
                    hold_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    hold_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            n_q     <= 8'h00;
            hi_q    <= 8'h00;
            lo_q    <= 8'h00;
            chk_q   <= 8'h00;
            addr_q  <= '0;
            wl_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            chk_q   <= chk_d;
            addr_q  <= addr_d;
            wl_q    <= wl_d;
            done_q  <= done_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
        end
    end

    assign iram_wen     = (state_q == ST_WRITE);
    assign iram_wa      = addr_q;
    assign iram_din     = {hi_q, lo_q};
    assign cpu_hold     = hold_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = wl_q;

endmodule

// File: tb/tb_uart_iram_loader.sv
// Scoreboard bench for uart_iram_loader: FIFO model feeds frames,
// expected IRAM writes are queued and matched as iram_wen pulses.
module tb_uart_iram_loader;

    logic        clk;
    logic        reset;
    logic        rx_empty;
    logic [7:0]  r_data;
    logic        rd_uart;
    logic [7:0]  iram_wa;
    logic        iram_wen;
    logic [15:0] iram_din;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [8:0]  words_loaded;

    int n_checks;
    int n_fail;
    int wr_seen;
    logic [7:0]  last_wa;
    logic [7:0]  fifo[$];
    logic [23:0] exp_q[$];
    logic [23:0] exp_item;
    logic        pend_pop;
    logic        prev_rd;

    uart_iram_loader #(
        .WIDTH(16),
        .IRAM_ADDR_BITS(8),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_empty    (rx_empty),
        .r_data      (r_data),
        .rd_uart     (rd_uart),
        .iram_wa     (iram_wa),
        .iram_wen    (iram_wen),
        .iram_din    (iram_din),
        .cpu_hold    (cpu_hold),
        .done        (done),
        .err         (err),
        .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: pops decided at the negedge take effect just after the edge.
    always @(posedge clk) begin
        #1;
        if (pend_pop && fifo.size() > 0) void'(fifo.pop_front());
        pend_pop = 1'b0;
        rx_empty = (fifo.size() == 0);
        r_data   = rx_empty ? 8'h00 : fifo[0];
    end

    always @(negedge clk) begin
        if (iram_wen) begin
            wr_seen++;
            last_wa = iram_wa;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wr_unexpected: got addr=%h data=%h, required no write",
                         iram_wa, iram_din);
            end else begin
                exp_item = exp_q.pop_front();
                if ({iram_wa, iram_din} !== exp_item) begin
                    n_fail++;
                    $display("FAIL wr_data: got addr=%h data=%h, required addr=%h data=%h",
                             iram_wa, iram_din, exp_item[23:16], exp_item[15:0]);
                end
            end
        end
        if (rd_uart) begin
            n_checks++;
            if (rx_empty || prev_rd) begin
                n_fail++;
                $display("FAIL rd_uart_rule: got rx_empty=%b prev_rd=%b, required both 0",
                         rx_empty, prev_rd);
            end
        end
        prev_rd  = rd_uart;
        pend_pop = rd_uart;
    end

    task automatic push_frame(input logic [7:0] len, input logic [7:0] chk_adj,
                              input int nbytes, input logic [15:0] seed);
        logic [7:0] chk;
        logic [7:0] hb;
        logic [7:0] lb;
        chk = 8'h00;
        fifo.push_back(len);
        for (int i = 0; i < nbytes / 2; i++) begin
            hb = seed[15:8] + 8'(i * 7);
            lb = seed[7:0] ^ 8'(i * 13);
            fifo.push_back(hb);
            fifo.push_back(lb);
            chk = chk ^ hb ^ lb;
            exp_q.push_back({8'(i), hb, lb});
        end
        fifo.push_back(chk ^ chk_adj);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int c;
        c = 0;
        @(negedge clk);
        while (!(fifo.size() == 0 && !cpu_hold && !rd_uart) && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (c >= budget) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no idle within %0d cycles, required idle", name, budget);
        end
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        rx_empty = 1'b1;
        r_data   = 8'h00;
        pend_pop = 1'b0;
        prev_rd  = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rd_uart, iram_wen, iram_wa, iram_din} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_port: got %h, required 0", {rd_uart, iram_wen, iram_wa, iram_din});
        end
        n_checks++;
        if ({cpu_hold, done, err, words_loaded} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_status: got %h, required 0", {cpu_hold, done, err, words_loaded});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_good;
        int w0;
        w0 = wr_seen;
        fifo.push_back(8'h02);
        fifo.push_back(8'h12); fifo.push_back(8'h34);
        fifo.push_back(8'hAB); fifo.push_back(8'hCD);
        fifo.push_back(8'h40);
        exp_q.push_back({8'h00, 16'h1234});
        exp_q.push_back({8'h01, 16'hABCD});
        wait_idle(200, "good");
        n_checks++;
        if ({done, err} !== 2'b10) begin
            n_fail++;
            $display("FAIL good_flags: got done=%b err=%b, required done=1 err=0", done, err);
        end
        n_checks++;
        if (words_loaded !== 9'd2) begin
            n_fail++;
            $display("FAIL good_words: got %0d, required 2", words_loaded);
        end
        n_checks++;
        if (cpu_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL good_hold: got %b, required 0", cpu_hold);
        end
        n_checks++;
        if (wr_seen - w0 != 2 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL good_wrcount: got %0d writes pending=%0d, required 2 and 0",
                     wr_seen - w0, exp_q.size());
        end
    endtask

    task automatic test_bad_chk;
        int w0;
        w0 = wr_seen;
        fifo.push_back(8'h02);
        fifo.push_back(8'h12); fifo.push_back(8'h34);
        fifo.push_back(8'hAB); fifo.push_back(8'hCD);
        fifo.push_back(8'h41);
        exp_q.push_back({8'h00, 16'h1234});
        exp_q.push_back({8'h01, 16'hABCD});
        wait_idle(200, "badchk");
        n_checks++;
        if ({done, err} !== 2'b01) begin
            n_fail++;
            $display("FAIL bad_flags: got done=%b err=%b, required done=0 err=1", done, err);
        end
        n_checks++;
        if (wr_seen - w0 != 2 || words_loaded !== 9'd2) begin
            n_fail++;
            $display("FAIL bad_words: got writes=%0d words=%0d, required 2 and 2",
                     wr_seen - w0, words_loaded);
        end
    endtask

    task automatic test_zero;
        int w0;
        w0 = wr_seen;
        fifo.push_back(8'h00);
        fifo.push_back(8'h00);
        wait_idle(100, "zero");
        n_checks++;
        if ({done, err} !== 2'b10) begin
            n_fail++;
            $display("FAIL zero_flags: got done=%b err=%b, required done=1 err=0", done, err);
        end
        n_checks++;
        if (wr_seen != w0 || words_loaded !== 9'd0) begin
            n_fail++;
            $display("FAIL zero_words: got writes=%0d words=%0d, required 0 and 0",
                     wr_seen - w0, words_loaded);
        end
    endtask

    task automatic test_timeout;
        int w;
        int k;
        bit hit;
        w   = 0;
        k   = 0;
        hit = 0;
        fifo.push_back(8'h03);
        fifo.push_back(8'h01); fifo.push_back(8'h02);
        fifo.push_back(8'h03); fifo.push_back(8'h04);
        exp_q.push_back({8'h00, 16'h0102});
        exp_q.push_back({8'h01, 16'h0304});
        for (int c = 0; c < 400 && !hit; c++) begin
            @(negedge clk);
            if (w >= 2) k++;
            if (iram_wen) w++;
            if (w >= 2 && err) hit = 1;
        end
        n_checks++;
        if (!hit || k < 50 || k > 52) begin
            n_fail++;
            $display("FAIL tmo_latency: got hit=%0d after %0d idle clocks, required err near 51",
                     hit, k);
        end
        n_checks++;
        if (words_loaded !== 9'd2 || cpu_hold !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_state: got words=%0d hold=%b done=%b, required 2 0 0",
                     words_loaded, cpu_hold, done);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL tmo_pending: got %0d writes missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back;
        int w0;
        w0 = wr_seen;
        push_frame(8'd255, 8'h00, 510, 16'($urandom));
        wait_idle(5000, "b2b");
        n_checks++;
        if ({done, err} !== 2'b10 || words_loaded !== 9'd255) begin
            n_fail++;
            $display("FAIL b2b_flags: got done=%b err=%b words=%0d, required 1 0 255",
                     done, err, words_loaded);
        end
        n_checks++;
        if (wr_seen - w0 != 255 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d writes pending=%0d, required 255 and 0",
                     wr_seen - w0, exp_q.size());
        end
        n_checks++;
        if (last_wa !== 8'd254) begin
            n_fail++;
            $display("FAIL b2b_lastaddr: got %0d, required 254", last_wa);
        end
    endtask

    task automatic test_reset_mid;
        int c;
        fifo.push_back(8'h02);
        fifo.push_back(8'h11); fifo.push_back(8'h22);
        fifo.push_back(8'h33);
        exp_q.push_back({8'h00, 16'h1122});
        c = 0;
        while (fifo.size() != 0 && c < 100) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (cpu_hold !== 1'b1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL mid_pre: got hold=%b pending=%0d, required 1 and 0",
                     cpu_hold, exp_q.size());
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({rd_uart, iram_wen, iram_wa, iram_din, cpu_hold, done, err, words_loaded} !== 38'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got %h, required 0",
                     {rd_uart, iram_wen, iram_wa, iram_din, cpu_hold, done, err, words_loaded});
        end
        fifo.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        fifo.push_back(8'h01);
        fifo.push_back(8'hAA); fifo.push_back(8'h55);
        fifo.push_back(8'hFF);
        exp_q.push_back({8'h00, 16'hAA55});
        wait_idle(200, "postreset");
        n_checks++;
        if ({done, err} !== 2'b10 || words_loaded !== 9'd1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL post_reset: got done=%b err=%b words=%0d pending=%0d, required 1 0 1 0",
                     done, err, words_loaded, exp_q.size());
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        wr_seen  = 0;
        last_wa  = 8'h00;
        test_reset;
        test_good;
        test_bad_chk;
        test_zero;
        test_timeout;
        test_back_to_back;
        test_reset_mid;
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_iram_loader.md
Name: uart_iram_loader

Overview:
- Consumes bytes from the UART receive FIFO and assembles them into 16-bit instruction words, MSB byte first.
- Writes the words sequentially into the micro's instruction RAM write port (iram_wa/iram_wen/iram_din).
- Framed protocol: length byte, data bytes, XOR checksum byte.
- Holds the CPU in reset while a load is in progress, so it never fetches a half-written program.

Parameters:
- WIDTH, 16, instruction word width; fixed at 2 bytes per word.
- IRAM_ADDR_BITS, 8, IRAM address width.
- TIMEOUT_CYCLES, 1_000_000, maximum idle clocks between bytes inside a frame before abort.

Ports:
- clk  in  1  system clock; the UART FIFO side and the IRAM port share this clock.
- reset  in  1  asynchronous, active-high reset.
- rx_empty  in  1  UART FIFO empty flag.
- r_data  in  8  UART FIFO head byte; valid while rx_empty=0.
- rd_uart  out  1  one-cycle pop strobe to the FIFO.
- iram_wa  out  IRAM_ADDR_BITS  IRAM write address.
- iram_wen  out  1  IRAM write enable; one-cycle pulse per word.
- iram_din  out  WIDTH  IRAM write data.
- cpu_hold  out  1  high while a frame is in progress; ORed into the micro reset.
- done  out  1  level, high after a frame completes with a good checksum.
- err  out  1  level, high after checksum mismatch or timeout.
- words_loaded  out  IRAM_ADDR_BITS+1  count of words written in the last or current frame.

Behaviour:
- Reset: all outputs 0, state IDLE, address 0, checksum 0, timeout counter 0.
- Byte acceptance:
  - A byte is consumed in a cycle where rx_empty=0, a read state is active, and pop_guard=0.
  - In that cycle the block latches r_data and pulses rd_uart=1.
  - pop_guard is set for the following cycle, so the FIFO flags settle before the next sample. Maximum rate is 1 byte per 2 clocks.
- States:
  - IDLE: on the first accepted byte, latch N = byte; clear checksum, address, words_loaded, done, err; set cpu_hold=1.
    - N=0: go to CHK.
    - Otherwise: go to RD_HI.
  - RD_HI: accept a byte into hi[7:0]; checksum ^= byte; go to RD_LO.
  - RD_LO: accept a byte; checksum ^= byte; go to WRITE.
  - WRITE (one cycle):
    - iram_din={hi,byte}, iram_wa=addr, iram_wen=1.
    - Then addr+1 and words_loaded+1.
    - If words_loaded+1==N go to CHK, else go to RD_HI.
  - CHK: accept a byte and compare it with the checksum (the length byte is excluded from the checksum).
    - Equal: done=1. Mismatch: err=1.
    - Then cpu_hold=0 and go to IDLE.
- Latency: iram_wen asserts exactly 1 clock after the cycle in which the LO byte is accepted.
- Address wrap: addr is IRAM_ADDR_BITS wide and wraps 255→0. With N≤255 no wrap occurs within a frame.
- Timeout:
  - In RD_HI, RD_LO and CHK, the counter increments each cycle without an accepted byte and resets on acceptance.
  - Reaching TIMEOUT_CYCLES sets err=1, cpu_hold=0, state IDLE.
  - Words already written stay written; words_loaded keeps the partial count.
- IDLE has no timeout. A new frame clears done and err.
- Asynchronous reset mid-frame: immediate return to the reset state. cpu_hold drops, so the micro's own reset governs.
- iram_wen is never asserted outside WRITE; rd_uart is never asserted when rx_empty=1.

Decomposition:
- Shared package/header holds:
  - state encoding localparams ST_IDLE, ST_RD_HI, ST_RD_LO, ST_WRITE, ST_CHK;
  - BYTES_PER_WORD=2.
- One natural sub-module: uart_byte_fetch. It owns the pop_guard/rd_uart handshake and the timeout counter, and presents byte_valid/byte/timeout to the frame FSM.
- Everything else is a single FSM in the top module.

Test Plan:
- Frame 02, 12 34, AB CD, checksum (12^34^AB^CD)=40 →
  - writes addr0=1234, addr1=ABCD;
  - words_loaded=2, done=1, err=0;
  - cpu_hold low after the checksum byte.
- Same frame with checksum 41 → both words written, err=1, done=0.
- Frame 00 00 → no iram_wen pulses, done=1, words_loaded=0.
- Frame 03 with 4 data bytes then silence (TIMEOUT_CYCLES=50 in the bench) → err=1 after 50 idle clocks; words_loaded=2; cpu_hold=0.
- FIFO model with back-to-back bytes available → rd_uart never asserted on consecutive cycles; no byte lost or duplicated across a 255-word frame; last write at addr 254.
- Assert reset during RD_LO of word 1 → all outputs 0 within the same cycle. A subsequent clean frame loads correctly starting at addr 0.
